pll_lock_supervisor: RTL and testbench

Multi-channel supervisor for the fabric PLL/CCC instances of the digitizer. It holds up to NUM_PLL PLLs through a power-down/relock sequence and filters their asynchronous LOCK outputs. It also retries failed lock attempts with a timeout and releases one staggered domain reset per PLL only after a stable lock. It sits between the CCC wrappers (PLL_POWERDOWN_N / PLL_LOCK) and the reset tree of each derived clock domain, running on the free-running board reference clock.

---
 rtl/pll_lock_supervisor_if.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 167 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL supervisor and its environment.
// The master side drives the per-channel requests and raw lock; the slave side is the supervisor.
interface pll_lock_supervisor_if #(
    parameter int NUM_PLL = 2
);
    logic [NUM_PLL-1:0]       enable;
    logic [NUM_PLL-1:0]       relock_req;
    logic [NUM_PLL-1:0]       pll_lock;
    logic [NUM_PLL-1:0]       pll_powerdown_n;
    logic [NUM_PLL-1:0]       locked;
    logic [NUM_PLL-1:0]       domain_rst_n;
    logic [NUM_PLL-1:0]       fault;
    logic [NUM_PLL-1:0][7:0]  loss_cnt;

    modport master (
        output enable, relock_req, pll_lock,
        input  pll_powerdown_n, locked, domain_rst_n, fault, loss_cnt
    );

    modport slave (
        input  enable, relock_req, pll_lock,
        output pll_powerdown_n, locked, domain_rst_n, fault, loss_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Per-PLL power-down/relock sequencer with lock filtering, retry/timeout and staggered
// domain reset release; one independent channel FSM per supervised PLL.
module pll_lock_chan #(
    parameter int PWRDN_CYCLES = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_HOLD     = 256,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       relock_req,
    input  logic       pll_lock,
    output logic       pll_powerdown_n,
    output logic       locked,
    output logic       domain_rst_n,
    output logic       fault,
    output logic [7:0] loss_cnt
);
    localparam int FW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PWRDN_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [FW-1:0]    FL_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [RW-1:0]    RT_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_OFF, S_PWRDN, S_WAIT, S_FILTER, S_HOLD, S_RUN, S_FAULT
    } st_t;

    st_t              state_q, state_d;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] timer_q;
    logic [FW-1:0]    fcnt_q;
    logic [RW-1:0]    retry_q;
    logic             lock_s, tmr_clr, cnt_en, relock, retry_inc, loss_ev;
    logic             pdn_d, locked_d, drn_d, fault_d;

    assign lock_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            sync_q          <= '0;
            state_q         <= S_OFF;
            timer_q         <= '0;
            fcnt_q          <= '0;
            retry_q         <= '0;
            loss_cnt        <= '0;
            pll_powerdown_n <= 1'b0;
            locked          <= 1'b0;
            domain_rst_n    <= 1'b0;
            fault           <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pll_lock};
            state_q <= state_d;
            if (tmr_clr)     timer_q <= '0;
            else if (cnt_en) timer_q <= timer_q + 1'b1;
            // First qualifying sample is the one that moves WAIT -> FILTER.
            fcnt_q <= (state_d != S_FILTER) ? '0 :
                      (state_q == S_FILTER) ? fcnt_q + 1'b1 : FW'(1);
            if (state_d == S_OFF || relock || (state_d == S_HOLD && state_q != S_HOLD))
                retry_q <= '0;
            else if (retry_inc)
                retry_q <= retry_q + 1'b1;
            if (loss_ev && loss_cnt != 8'hFF)
                loss_cnt <= loss_cnt + 1'b1;
            pll_powerdown_n <= pdn_d;
            locked          <= locked_d;
            domain_rst_n    <= drn_d;
            fault           <= fault_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        relock    = 1'b0;
        retry_inc = 1'b0;
        loss_ev   = 1'b0;
        if (!enable) begin
            state_d = S_OFF;
        end else if (relock_req && state_q != S_OFF) begin
            state_d = S_PWRDN;
            relock  = 1'b1;
        end else begin
            case (state_q)
                S_OFF:   state_d = S_PWRDN;
                S_PWRDN: if (timer_q == PD_LAST) state_d = S_WAIT;
                S_WAIT, S_FILTER: begin
                    if (timer_q == TO_LAST) begin
                        if (retry_q < RT_MAX) begin
                            retry_inc = 1'b1;
                            state_d   = S_PWRDN;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end else if (!lock_s) begin
                        state_d = S_WAIT;
                    end else if ((state_q == S_WAIT) ? (LOCK_FILTER == 1) : (fcnt_q == FL_LAST)) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_FILTER;
                    end
                end
                S_HOLD, S_RUN: begin
                    if (!lock_s) begin
                        loss_ev = 1'b1;
                        state_d = S_PWRDN;
                    end else if (state_q == S_HOLD && timer_q == RH_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_OFF;
            endcase
        end
        // WAIT <-> FILTER shares one timeout window; every other move restarts the timer.
        cnt_en  = state_q inside {S_PWRDN, S_WAIT, S_FILTER, S_HOLD};
        tmr_clr = relock || ((state_d != state_q) &&
                  !((state_q inside {S_WAIT, S_FILTER}) && (state_d inside {S_WAIT, S_FILTER})));
    end

    always_comb begin : outputs_d
        pdn_d    = state_d inside {S_WAIT, S_FILTER, S_HOLD, S_RUN};
        locked_d = state_d inside {S_HOLD, S_RUN};
        drn_d    = (state_d == S_RUN);
        fault_d  = (state_d == S_FAULT);
    end
endmodule

module pll_lock_supervisor #(
    parameter int NUM_PLL      = 2,
    parameter int PWRDN_CYCLES = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_HOLD     = 256,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16
) (
    input  logic                 ref_clk,
    input  logic                 reset_n,
    pll_lock_supervisor_if.slave bus
);
    for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
        pll_lock_chan #(
            .PWRDN_CYCLES (PWRDN_CYCLES),
            .LOCK_FILTER  (LOCK_FILTER),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .RST_HOLD     (RST_HOLD),
            .MAX_RETRY    (MAX_RETRY),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk             (ref_clk),
            .rst_n           (reset_n),
            .enable          (bus.enable[g]),
            .relock_req      (bus.relock_req[g]),
            .pll_lock        (bus.pll_lock[g]),
            .pll_powerdown_n (bus.pll_powerdown_n[g]),
            .locked          (bus.locked[g]),
            .domain_rst_n    (bus.domain_rst_n[g]),
            .fault           (bus.fault[g]),
            .loss_cnt        (bus.loss_cnt[g])
        );
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench: edge-indexed vector tables for nominal/timeout/independence, plus
// hand sequences for glitch filtering, loss counting, priority and async reset.
module tb_pll_lock_supervisor;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor_if #(.NUM_PLL(2)) bus ();

    pll_lock_supervisor #(
        .NUM_PLL(2), .PWRDN_CYCLES(4), .LOCK_FILTER(8), .LOCK_TIMEOUT(100),
        .RST_HOLD(16), .MAX_RETRY(2), .CNT_W(16)
    ) dut (
        .ref_clk (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int         at;
        logic [1:0] en, lock, rl;
        logic [1:0] pdn, lck, drn, flt;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.enable = '0; bus.relock_req = '0; bus.pll_lock = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic v(input int at, input logic [1:0] en, lock, rl, pdn, lck, drn, flt);
        tv.push_back('{at, en, lock, rl, pdn, lck, drn, flt});
    endtask

    // Outputs are compared after edge 'at', then the record's inputs are driven for the next edge.
    task automatic run_table(input string tag);
        for (int i = 0; i < tv.size(); i++) begin
            step_to(tv[i].at);
            chk($sformatf("%s[%0d].pdn", tag, tv[i].at), 32'(bus.pll_powerdown_n), 32'(tv[i].pdn));
            chk($sformatf("%s[%0d].lck", tag, tv[i].at), 32'(bus.locked),          32'(tv[i].lck));
            chk($sformatf("%s[%0d].drn", tag, tv[i].at), 32'(bus.domain_rst_n),    32'(tv[i].drn));
            chk($sformatf("%s[%0d].flt", tag, tv[i].at), 32'(bus.fault),           32'(tv[i].flt));
            bus.enable = tv[i].en; bus.pll_lock = tv[i].lock; bus.relock_req = tv[i].rl;
            if (tv[i].rl != 2'b00) begin
                step();
                bus.relock_req = '0;
            end
        end
        tv.delete();
    endtask

    // sel 0: locked[0], sel 1: domain_rst_n[0]
    task automatic wait_bit(input int sel, input logic val, input int budget, output logic ok);
        int n = 0;
        logic cur;
        cur = (sel == 0) ? bus.locked[0] : bus.domain_rst_n[0];
        while (cur !== val && n < budget) begin
            step();
            n++;
            cur = (sel == 0) ? bus.locked[0] : bus.domain_rst_n[0];
        end
        ok = (cur === val);
    endtask

    logic glitch_seen;
    task automatic step_mon(input int n);
        while (cyc < n) begin
            step();
            if (bus.locked[0] !== 1'b0) glitch_seen = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   bad;
        int   r0;

        // Nominal lock on channel 0; channel 1 idle.
        do_reset();
        v( 0, 2'b00, 2'b00, 2'b00,  2'b00, 2'b00, 2'b00, 2'b00);
        v( 9, 2'b01, 2'b00, 2'b00,  2'b00, 2'b00, 2'b00, 2'b00);
        v(14, 2'b01, 2'b00, 2'b00,  2'b00, 2'b00, 2'b00, 2'b00);
        v(15, 2'b01, 2'b00, 2'b00,  2'b01, 2'b00, 2'b00, 2'b00);
        v(30, 2'b01, 2'b01, 2'b00,  2'b01, 2'b00, 2'b00, 2'b00);
        v(39, 2'b01, 2'b01, 2'b00,  2'b01, 2'b00, 2'b00, 2'b00);
        v(40, 2'b01, 2'b01, 2'b00,  2'b01, 2'b01, 2'b00, 2'b00);
        v(55, 2'b01, 2'b01, 2'b00,  2'b01, 2'b01, 2'b00, 2'b00);
        v(56, 2'b01, 2'b01, 2'b00,  2'b01, 2'b01, 2'b01, 2'b00);
        v(70, 2'b01, 2'b01, 2'b00,  2'b01, 2'b01, 2'b01, 2'b00);
        run_table("nom");
        chk("nom.loss_cnt", 32'(bus.loss_cnt), 32'd0);

        // Ch0 never locks: attempts open at 15/121/227 for 101 edges, 5-edge power-down
        // windows between them, FAULT at 328. Ch1 locks nominally meanwhile. Relock at 341.
        do_reset();
        v(  0, 2'b00, 2'b00, 2'b00,  2'b00, 2'b00, 2'b00, 2'b00);
        v(  9, 2'b11, 2'b00, 2'b00,  2'b00, 2'b00, 2'b00, 2'b00);
        v( 14, 2'b11, 2'b00, 2'b00,  2'b00, 2'b00, 2'b00, 2'b00);
        v( 15, 2'b11, 2'b00, 2'b00,  2'b11, 2'b00, 2'b00, 2'b00);
        v( 30, 2'b11, 2'b10, 2'b00,  2'b11, 2'b00, 2'b00, 2'b00);
        v( 39, 2'b11, 2'b10, 2'b00,  2'b11, 2'b00, 2'b00, 2'b00);
        v( 40, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b00, 2'b00);
        v( 55, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b00, 2'b00);
        v( 56, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b10, 2'b00);
        v(115, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b10, 2'b00);
        v(116, 2'b11, 2'b10, 2'b00,  2'b10, 2'b10, 2'b10, 2'b00);
        v(120, 2'b11, 2'b10, 2'b00,  2'b10, 2'b10, 2'b10, 2'b00);
        v(121, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b10, 2'b00);
        v(221, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b10, 2'b00);
        v(222, 2'b11, 2'b10, 2'b00,  2'b10, 2'b10, 2'b10, 2'b00);
        v(226, 2'b11, 2'b10, 2'b00,  2'b10, 2'b10, 2'b10, 2'b00);
        v(227, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b10, 2'b00);
        v(327, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b10, 2'b00);
        v(328, 2'b11, 2'b10, 2'b00,  2'b10, 2'b10, 2'b10, 2'b01);
        v(340, 2'b11, 2'b10, 2'b01,  2'b10, 2'b10, 2'b10, 2'b01);
        v(342, 2'b11, 2'b10, 2'b00,  2'b10, 2'b10, 2'b10, 2'b00);
        v(345, 2'b11, 2'b10, 2'b00,  2'b10, 2'b10, 2'b10, 2'b00);
        v(346, 2'b11, 2'b10, 2'b00,  2'b11, 2'b10, 2'b10, 2'b00);
        run_table("tmo");

        // Glitch: 5 high, 2 low, then steady high from after edge 357 -> LOCKED at 367.
        glitch_seen = 1'b0;
        step_to(350);
        bus.pll_lock[0] = 1'b1;
        step_mon(355);
        bus.pll_lock[0] = 1'b0;
        step_mon(357);
        bus.pll_lock[0] = 1'b1;
        step_mon(366);
        chk("glitch.no_early_lock", 32'(glitch_seen), 32'd0);
        step_to(367);
        chk("glitch.locked", 32'(bus.locked[0]), 32'd1);

        // Loss in RUN: drop after edge 390 -> LOCKED/DOMAIN_RST_N/POWERDOWN_N fall at 393.
        step_to(383);
        chk("loss.drn_up", 32'(bus.domain_rst_n[0]), 32'd1);
        step_to(390);
        bus.pll_lock[0] = 1'b0;
        step_to(392);
        chk("loss.still_locked", 32'({bus.locked[0], bus.domain_rst_n[0]}), 32'h3);
        step_to(393);
        chk("loss.outs_low", 32'({bus.pll_powerdown_n[0], bus.locked[0], bus.domain_rst_n[0]}), 32'h0);
        chk("loss.cnt1", 32'(bus.loss_cnt[0]), 32'd1);
        bus.pll_lock[0] = 1'b1;
        wait_bit(0, 1'b1, 40, ok);
        chk("loss.relock_auto", 32'(ok), 32'd1);

        // 259 more losses (260 total) -> counter saturates at 255.
        bad = 0;
        for (int i = 2; i <= 260; i++) begin
            bus.pll_lock[0] = 1'b0;
            wait_bit(0, 1'b0, 10, ok);
            if (!ok) bad++;
            bus.pll_lock[0] = 1'b1;
            wait_bit(0, 1'b1, 40, ok);
            if (!ok) bad++;
            if (i == 200) chk("sat.cnt200", 32'(bus.loss_cnt[0]), 32'd200);
        end
        chk("sat.loop_timeouts", 32'(bad), 32'd0);
        chk("sat.cnt255", 32'(bus.loss_cnt[0]), 32'd255);
        chk("sat.ch1_cnt", 32'(bus.loss_cnt[1]), 32'd0);

        // ENABLE=0 and RELOCK_REQ on the same edge in RUN: OFF wins, so the restart
        // (ENABLE back high next edge) raises POWERDOWN_N 6 edges later, not 5.
        wait_bit(1, 1'b1, 30, ok);
        chk("prio.in_run", 32'(ok), 32'd1);
        bus.enable[0] = 1'b0; bus.relock_req[0] = 1'b1;
        step();
        r0 = cyc;
        bus.enable[0] = 1'b1; bus.relock_req[0] = 1'b0;
        chk("prio.outs_off", 32'({bus.pll_powerdown_n[0], bus.locked[0],
                                  bus.domain_rst_n[0], bus.fault[0]}), 32'h0);
        step_to(r0 + 5);
        chk("prio.pdn_low", 32'(bus.pll_powerdown_n[0]), 32'd0);
        step_to(r0 + 6);
        chk("prio.pdn_high", 32'(bus.pll_powerdown_n[0]), 32'd1);

        // Async reset mid-FILTER on ch0 while ch1 runs.
        step_to(r0 + 9);
        chk("rst.pre_ch1_locked", 32'(bus.locked[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.pdn",  32'(bus.pll_powerdown_n), 32'd0);
        chk("rst.lck",  32'(bus.locked),          32'd0);
        chk("rst.drn",  32'(bus.domain_rst_n),    32'd0);
        chk("rst.flt",  32'(bus.fault),           32'd0);
        chk("rst.loss", 32'(bus.loss_cnt),        32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
